// File: rtl/tdc_hw_accum_if.sv
// Host readout interface for tdc_hw_accum: measurement request and results.
interface tdc_hw_accum_if #(
   parameter int unsigned HW_W = 7
);
   logic            start;
   logic [3:0]      n_log2;
   logic            busy;
   logic            done;
   logic [HW_W-1:0] hw_last;
   logic [HW_W-1:0] hw_mean;
   logic [HW_W-1:0] hw_min;
   logic [HW_W-1:0] hw_max;

   modport master (
      output start, n_log2,
      input  busy, done, hw_last, hw_mean, hw_min, hw_max
   );

   modport slave (
      input  start, n_log2,
      output busy, done, hw_last, hw_mean, hw_min, hw_max
   );
endinterface

// File: rtl/tdc_hw_accum.sv
// Hamming-weight TDC: launch pulse generation, tap capture, 2^n-sample mean.
// Optional min/max weight tracking is enabled by defining TDC_MINMAX_EN.
module tdc_hw_accum #(
   parameter int unsigned TAPS      = 64,
   parameter int unsigned TOG_DIV_W = 2,
   parameter int unsigned MAX_LOG2  = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            pg_in,
   input  logic            pg_src,
   input  logic            pg_bypass,
   output logic            pg_out,
   input  logic [TAPS-1:0] taps,
   tdc_hw_accum_if.slave   host
);
   localparam int unsigned HW_W  = $clog2(TAPS + 1);
   localparam int unsigned ACC_W = HW_W + MAX_LOG2;
   localparam int unsigned CNT_W = MAX_LOG2 + 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   logic [TOG_DIV_W-1:0] tog_cnt_q;
   logic                 s1_q;
   logic                 pg_out_q;
   logic [TAPS-1:0]      tap_q;
   logic [HW_W-1:0]      hw_last_q;

   state_t               state_q;
   logic [3:0]           n_q;
   logic [CNT_W-1:0]     cnt_q;
   logic [ACC_W-1:0]     acc_q;
   logic                 busy_q;
   logic                 done_q;
   logic [HW_W-1:0]      hw_mean_q;

   logic [ACC_W-1:0]     acc_d;
   logic [CNT_W-1:0]     last_cnt;
   logic [3:0]           n_clamp;

   // Launch path: free-running divider or (optionally double) synchronised pg_in
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tog_cnt_q <= '0;
         s1_q      <= 1'b0;
         pg_out_q  <= 1'b0;
      end else begin
         tog_cnt_q <= tog_cnt_q + TOG_DIV_W'(1);
         s1_q      <= pg_in;
         if (pg_src)         pg_out_q <= tog_cnt_q[TOG_DIV_W-1];
         else if (pg_bypass) pg_out_q <= pg_in;
         else                pg_out_q <= s1_q;
      end
   end

   // Capture path: tap vector then its weight one edge later
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tap_q     <= '0;
         hw_last_q <= '0;
      end else begin
         tap_q     <= taps;
         hw_last_q <= HW_W'($countones(tap_q));
      end
   end

   assign acc_d    = acc_q + ACC_W'(hw_last_q);
   assign last_cnt = CNT_W'((CNT_W'(1) << n_q) - CNT_W'(1));
   assign n_clamp  = (host.n_log2 > 4'(MAX_LOG2)) ? 4'(MAX_LOG2) : host.n_log2;

`ifdef TDC_MINMAX_EN
   logic [HW_W-1:0] min_r_q;
   logic [HW_W-1:0] max_r_q;
   logic [HW_W-1:0] min_d;
   logic [HW_W-1:0] max_d;
   logic [HW_W-1:0] hw_min_q;
   logic [HW_W-1:0] hw_max_q;

   assign min_d = (hw_last_q < min_r_q) ? hw_last_q : min_r_q;
   assign max_d = (hw_last_q > max_r_q) ? hw_last_q : max_r_q;

   // Running extrema, published alongside the mean on completion
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         min_r_q  <= '0;
         max_r_q  <= '0;
         hw_min_q <= '0;
         hw_max_q <= '0;
      end else if (state_q == S_IDLE && host.start) begin
         min_r_q <= '1;
         max_r_q <= '0;
      end else if (state_q == S_RUN) begin
         min_r_q <= min_d;
         max_r_q <= max_d;
         if (cnt_q == last_cnt) begin
            hw_min_q <= min_d;
            hw_max_q <= max_d;
         end
      end
   end

   assign host.hw_min = hw_min_q;
   assign host.hw_max = hw_max_q;
`else
   assign host.hw_min = '0;
   assign host.hw_max = '0;
`endif

   // Measurement FSM; busy/done are registered alongside the state
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         n_q       <= '0;
         cnt_q     <= '0;
         acc_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         hw_mean_q <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (host.start) begin
                  state_q <= S_RUN;
                  busy_q  <= 1'b1;
                  n_q     <= n_clamp;
                  cnt_q   <= '0;
                  acc_q   <= '0;
               end
            end
            S_RUN: begin
               acc_q <= acc_d;
               if (cnt_q == last_cnt) begin
                  state_q   <= S_DONE;
                  done_q    <= 1'b1;
                  hw_mean_q <= HW_W'(acc_d >> n_q);
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign pg_out       = pg_out_q;
   assign host.busy    = busy_q;
   assign host.done    = done_q;
   assign host.hw_last = hw_last_q;
   assign host.hw_mean = hw_mean_q;
endmodule
